// File: rtl/axi_pkg.sv
// Shared AXI4 constants, channel FSM state encodings and default IDs for the
// cache-bus to AXI4 master bridge.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [3:0] RD_ID_DEFAULT  = 4'h0;
  localparam logic [3:0] WR_ID_DEFAULT  = 4'h1;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  // Cache-side lengths are 4-bit beats-1; AXI4 carries 8 bits.
  function automatic logic [7:0] axi_len(input logic [3:0] len);
    return {4'h0, len};
  endfunction

endpackage

// File: rtl/axi_wr_channel.sv
// Write-side FSM of the bridge: issues AW, forwards W beats with a locally
// generated WLAST, and reports beat completion (final beat only after B).
module axi_wr_channel
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        ce_i,
  input  logic        wen_i,
  input  logic [31:0] waddr_i,
  input  logic [3:0]  wlen_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  output logic        wdata_resp_o,
  output logic        awvalid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  input  logic        awready_i,
  output logic        wvalid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  wr_state_e   state_q;
  logic        awvalid_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  sel_q;
  logic [3:0]  cnt_q;
  logic        in_data;
  logic        w_hs;

  assign in_data   = (state_q == W_DATA);
  assign awvalid_o = awvalid_q;
  assign awaddr_o  = addr_q;
  assign awlen_o   = len_q;
  assign wvalid_o  = in_data & wvalid_i;
  assign wdata_o   = wdata_i;
  assign wstrb_o   = sel_q;
  assign wlast_o   = in_data & (cnt_q == len_q);
  assign bready_o  = (state_q == W_RESP);
  assign w_hs      = wvalid_o & wready_i;

  // The last beat's completion is held back until the slave's B response.
  assign wdata_resp_o = (w_hs & ~wlast_o) | (bready_o & bvalid_i);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= W_IDLE;
      awvalid_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        W_IDLE: if (wen_i && ce_i) begin
          addr_q    <= waddr_i;
          len_q     <= wlen_i;
          sel_q     <= sel_i;
          cnt_q     <= '0;
          awvalid_q <= 1'b1;
          state_q   <= W_AW;
        end
        W_AW: if (awready_i) begin
          awvalid_q <= 1'b0;
          state_q   <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          cnt_q <= cnt_q + 4'd1;
          if (wlast_o) state_q <= W_RESP;
        end
        W_RESP: if (bvalid_i) state_q <= W_IDLE;
        default: state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_master_bridge.sv
// Converts the per-beat cache bus into AXI4 master channels with one read
// and one write burst outstanding; the read path is kept inline here.
module axi_master_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0] RD_ID = RD_ID_DEFAULT,
  parameter logic [3:0] WR_ID = WR_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ce_i,
  input  logic [3:0]  sel_i,
  input  logic        ren_i,
  input  logic        rready_i,
  input  logic [31:0] raddr_i,
  input  logic [3:0]  rlen_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  input  logic        wen_i,
  input  logic [31:0] waddr_i,
  input  logic [3:0]  wlen_i,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  input  logic        wlast_i,
  output logic        wdata_resp_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   rstate_q;
  logic        arvalid_q;
  logic [31:0] raddr_q;
  logic [3:0]  rlen_q;
  logic [3:0]  wlen_lat;
  logic        unused_ok;

  // IDs and responses are not acted on; everything is treated as OKAY.
  assign unused_ok = ^{wlast_i, rid, rresp, bid, bresp};

  assign arid    = RD_ID;
  assign araddr  = raddr_q;
  assign arlen   = axi_len(rlen_q);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;
  assign arvalid = arvalid_q;

  assign rready        = (rstate_q == R_DATA) & rready_i;
  assign rdata_valid_o = rvalid & rready;
  assign rdata_o       = rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q  <= R_IDLE;
      arvalid_q <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (ren_i && ce_i) begin
          raddr_q   <= raddr_i;
          rlen_q    <= rlen_i;
          arvalid_q <= 1'b1;
          rstate_q  <= R_AR;
        end
        R_AR: if (arready) begin
          arvalid_q <= 1'b0;
          rstate_q  <= R_DATA;
        end
        R_DATA: if (rvalid && rready && rlast) rstate_q <= R_IDLE;
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign awid    = WR_ID;
  assign wid     = WR_ID;
  assign awlen   = axi_len(wlen_lat);
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = 4'h0;
  assign awprot  = 3'h0;

  axi_wr_channel u_wr (
    .clk          (clk),
    .resetn       (resetn),
    .ce_i         (ce_i),
    .wen_i        (wen_i),
    .waddr_i      (waddr_i),
    .wlen_i       (wlen_i),
    .sel_i        (sel_i),
    .wdata_i      (wdata_i),
    .wvalid_i     (wvalid_i),
    .wdata_resp_o (wdata_resp_o),
    .awvalid_o    (awvalid),
    .awaddr_o     (awaddr),
    .awlen_o      (wlen_lat),
    .awready_i    (awready),
    .wvalid_o     (wvalid),
    .wdata_o      (wdata),
    .wstrb_o      (wstrb),
    .wlast_o      (wlast),
    .wready_i     (wready),
    .bvalid_i     (bvalid),
    .bready_o     (bready)
  );

endmodule
